// File: rtl/raggedstone_spinn_aer_if_status_tx_pkg.sv
// -----------------------------------------------------------------------------
// raggedstone_spinn_aer_if_status_tx_pkg
//
// Shared definitions for the status-packet transmitter: packet geometry,
// reset value of the registered go state, control sub-key, reason codes,
// header bit positions, FSM state encoding and the packed packet layout.
// -----------------------------------------------------------------------------
package raggedstone_spinn_aer_if_status_tx_pkg;

    localparam int PKT_BITS  = 72;
    localparam int MODE_BITS = 4;
    localparam int VKEY_BITS = 32;

    // go value assumed before the first sample after reset
    localparam logic INIT_GO = 1'b0;

    // Low byte of every status key identifies it as a control packet
    localparam logic [7:0] CTRL_SUB = 8'hFE;

    localparam logic [7:0] RSN_GO  = 8'h01;
    localparam logic [7:0] RSN_REQ = 8'h02;
    localparam logic [7:0] RSN_HB  = 8'h03;

    // Header bit positions
    localparam int HDR_PLD_BIT = 1;
    localparam int HDR_PAR_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] seq;
        logic [7:0] reason;
        logic [7:0] mode;
        logic [6:0] rsvd;
        logic       go;
    } payload_t;

    // Packet as transmitted: payload in [71:40], key in [39:8], header in [7:0]
    typedef struct packed {
        payload_t               payload;
        logic [VKEY_BITS-1:0]   key;
        logic [7:0]             header;
    } pkt_t;

endpackage

// File: rtl/raggedstone_status_hb_timer.sv
// -----------------------------------------------------------------------------
// raggedstone_status_hb_timer
//
// Free-running heartbeat timer. Counts 0..PERIOD-1 and pulses expire for one
// cycle while the count sits at PERIOD-1; the count wraps to 0 on that edge.
// PERIOD = 0 disables the timer: the count holds at 0 and expire never fires.
//
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset
//   expire - one-cycle heartbeat strobe
// -----------------------------------------------------------------------------
module raggedstone_status_hb_timer #(
    parameter logic [31:0] PERIOD = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic expire
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (PERIOD != 32'd0) begin
            if (cnt_q == PERIOD - 32'd1) begin
                expire = 1'b1;
                cnt_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/raggedstone_spinn_aer_if_status_tx.sv
// -----------------------------------------------------------------------------
// raggedstone_spinn_aer_if_status_tx
//
// Builds 72-bit status packets for the SpiNNaker AER link and hands them
// downstream over a valid/ready handshake. Three event sources feed sticky
// pending flags: a change of go, a host status request and the heartbeat
// timer. From IDLE the highest-priority pending flag (go > req > hb) is turned
// into a packet; the packet is held in SEND until accepted, after which the
// sequence number advances. Repeats of an already pending event merge.
//
// Parameters:
//   HB_PERIOD - heartbeat interval in clk cycles, 0 disables the heartbeat
//
// Ports:
//   rst       - asynchronous active-high reset
//   clk       - clock
//   go        - current go state from the control receiver
//   vmode     - current virtual mode
//   vkey      - current virtual key (low byte replaced by CTRL_SUB)
//   stat_req  - one-cycle host request for a status packet
//   spkt_data - status packet
//   spkt_vld  - packet valid
//   spkt_rdy  - downstream ready
// -----------------------------------------------------------------------------
module raggedstone_spinn_aer_if_status_tx
    import raggedstone_spinn_aer_if_status_tx_pkg::*;
#(
    parameter logic [31:0] HB_PERIOD = 32'd1_000_000
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 go,
    input  logic [MODE_BITS-1:0] vmode,
    input  logic [VKEY_BITS-1:0] vkey,
    input  logic                 stat_req,
    output logic [PKT_BITS-1:0]  spkt_data,
    output logic                 spkt_vld,
    input  logic                 spkt_rdy
);

    state_e              state_q, state_d;
    logic                go_prev_q;
    logic                go_pend_q, go_pend_d;
    logic                req_pend_q, req_pend_d;
    logic                hb_pend_q, hb_pend_d;
    logic [7:0]          seq_q, seq_d;
    logic [PKT_BITS-1:0] data_q, data_d;
    logic                vld_q, vld_d;

    logic                hb_expire;
    logic                go_evt;
    logic                clr_go, clr_req, clr_hb;
    logic [7:0]          load_reason;
    pkt_t                pkt_body;
    logic                pkt_par;
    logic [PKT_BITS-1:0] pkt_next;

    // The key's low byte is overwritten by CTRL_SUB
    logic [7:0]          vkey_sub_unused;
    assign vkey_sub_unused = vkey[7:0];

    raggedstone_status_hb_timer #(
        .PERIOD (HB_PERIOD)
    ) u_hb_timer (
        .clk    (clk),
        .rst    (rst),
        .expire (hb_expire)
    );

    assign go_evt = (go != go_prev_q);

    // Reason follows the flag that will be serviced next
    always_comb begin
        load_reason = RSN_HB;
        if (go_pend_q) begin
            load_reason = RSN_GO;
        end else if (req_pend_q) begin
            load_reason = RSN_REQ;
        end
    end

    // Packet candidate with the parity bit still zero
    always_comb begin
        pkt_body                     = '0;
        pkt_body.header[HDR_PLD_BIT] = 1'b1;
        pkt_body.key                 = {vkey[VKEY_BITS-1:8], CTRL_SUB};
        pkt_body.payload.seq         = seq_q;
        pkt_body.payload.reason      = load_reason;
        pkt_body.payload.mode        = 8'(vmode);
        pkt_body.payload.go          = go;
    end

    // Odd parity over the full 72 bits: the parity bit is set when the rest
    // holds an even number of ones.
    assign pkt_par  = ~^pkt_body;
    assign pkt_next = {pkt_body[PKT_BITS-1:1], pkt_par};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        seq_d   = seq_q;
        clr_go  = 1'b0;
        clr_req = 1'b0;
        clr_hb  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go_pend_q || req_pend_q || hb_pend_q) begin
                    data_d  = pkt_next;
                    vld_d   = 1'b1;
                    state_d = ST_SEND;
                    clr_go  = go_pend_q;
                    clr_req = !go_pend_q && req_pend_q;
                    clr_hb  = !go_pend_q && !req_pend_q && hb_pend_q;
                end
            end
            ST_SEND: begin
                if (spkt_rdy) begin
                    vld_d   = 1'b0;
                    seq_d   = seq_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new event wins over the clear of the flag being loaded, so an event
    // arriving on the load edge yields a further packet instead of vanishing.
    assign go_pend_d  = (go_pend_q  && !clr_go)  || go_evt;
    assign req_pend_d = (req_pend_q && !clr_req) || stat_req;
    assign hb_pend_d  = (hb_pend_q  && !clr_hb)  || hb_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            go_prev_q  <= INIT_GO;
            go_pend_q  <= 1'b0;
            req_pend_q <= 1'b0;
            hb_pend_q  <= 1'b0;
            seq_q      <= 8'd0;
            data_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_prev_q  <= go;
            go_pend_q  <= go_pend_d;
            req_pend_q <= req_pend_d;
            hb_pend_q  <= hb_pend_d;
            seq_q      <= seq_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
        end
    end

    assign spkt_data = data_q;
    assign spkt_vld  = vld_q;

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_status_tx.sv
// -----------------------------------------------------------------------------
// Bench for raggedstone_spinn_aer_if_status_tx.
// Instance dut_a has the heartbeat disabled and carries the go / request /
// backpressure / merge / wrap / reset scenarios; dut_b runs HB_PERIOD = 16 for
// the simultaneous-event and heartbeat scenarios. Inputs change 1 time unit
// after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_raggedstone_spinn_aer_if_status_tx;

    logic        clk;
    logic        a_rst, a_go, a_req, a_rdy, a_vld;
    logic [3:0]  a_mode;
    logic [31:0] a_key;
    logic [71:0] a_data;
    logic        b_rst, b_go, b_req, b_rdy, b_vld;
    logic [3:0]  b_mode;
    logic [31:0] b_key;
    logic [71:0] b_data;

    int n_checks = 0;
    int n_pass   = 0;

    raggedstone_spinn_aer_if_status_tx #(.HB_PERIOD(32'd0)) dut_a (
        .rst(a_rst), .clk(clk), .go(a_go), .vmode(a_mode), .vkey(a_key),
        .stat_req(a_req), .spkt_data(a_data), .spkt_vld(a_vld), .spkt_rdy(a_rdy)
    );

    raggedstone_spinn_aer_if_status_tx #(.HB_PERIOD(32'd16)) dut_b (
        .rst(b_rst), .clk(clk), .go(b_go), .vmode(b_mode), .vkey(b_key),
        .stat_req(b_req), .spkt_data(b_data), .spkt_vld(b_vld), .spkt_rdy(b_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns as soon as dut_a shows valid, or after budget edges
    task automatic wait_a_vld(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (a_vld) return;
            tick();
        end
    endtask

    // Independent packet builder: header 7'b0000001 + odd parity bit
    function automatic logic [71:0] exp_pkt(input logic [7:0] seq, input logic [7:0] rsn,
                                            input logic [3:0] mode, input logic g,
                                            input logic [31:0] key);
        logic [70:0] body;
        body = {seq, rsn, 4'h0, mode, 7'b0, g, key[31:8], 8'hFE, 7'b0000001};
        return {body, ~^body};
    endfunction

    typedef struct {
        bit          use_go;
        logic        go;
        logic [3:0]  mode;
        logic [31:0] key;
        logic [71:0] exp;
    } vec_t;

    typedef struct {
        int          edge_n;
        logic [71:0] exp;
    } bexp_t;

    vec_t  vecs[4];
    bexp_t bexp[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [71:0] cap;
        int          cnt;
        int          nb;
        int          b_edge[8];
        logic [71:0] b_got[8];

        vecs[0] = '{use_go: 1'b0, go: 1'b1, mode: 4'h0, key: 32'hFFFF_FFFF,
                    exp: exp_pkt(8'd2, 8'h02, 4'h0, 1'b1, 32'hFFFF_FFFF)};
        vecs[1] = '{use_go: 1'b1, go: 1'b0, mode: 4'hF, key: 32'h0000_0000,
                    exp: exp_pkt(8'd3, 8'h01, 4'hF, 1'b0, 32'h0000_0000)};
        vecs[2] = '{use_go: 1'b0, go: 1'b0, mode: 4'h5, key: 32'hA5A5_0000,
                    exp: exp_pkt(8'd4, 8'h02, 4'h5, 1'b0, 32'hA5A5_0000)};
        vecs[3] = '{use_go: 1'b1, go: 1'b1, mode: 4'hA, key: 32'h0000_00FF,
                    exp: exp_pkt(8'd5, 8'h01, 4'hA, 1'b1, 32'h0000_00FF)};

        // dut_b: reset released after edge 0; first expiry samples at edge 16
        bexp[0] = '{edge_n: 17, exp: exp_pkt(8'd0, 8'h01, 4'h2, 1'b1, 32'hCAFE_BA00)};
        bexp[1] = '{edge_n: 19, exp: exp_pkt(8'd1, 8'h02, 4'h2, 1'b1, 32'hCAFE_BA00)};
        bexp[2] = '{edge_n: 21, exp: exp_pkt(8'd2, 8'h03, 4'h2, 1'b1, 32'hCAFE_BA00)};
        bexp[3] = '{edge_n: 33, exp: exp_pkt(8'd3, 8'h03, 4'h2, 1'b1, 32'hCAFE_BA00)};
        bexp[4] = '{edge_n: 49, exp: exp_pkt(8'd4, 8'h03, 4'h2, 1'b1, 32'hCAFE_BA00)};
        bexp[5] = '{edge_n: 65, exp: exp_pkt(8'd5, 8'h03, 4'h2, 1'b1, 32'hCAFE_BA00)};

        a_rst = 1'b1; a_go = 1'b0; a_req = 1'b0; a_rdy = 1'b0; a_mode = 4'h0; a_key = 32'h0;
        b_rst = 1'b1; b_go = 1'b0; b_req = 1'b0; b_rdy = 1'b1; b_mode = 4'h2; b_key = 32'hCAFE_BA00;

        #1;
        check("reset_vld", a_vld, 1'b0);
        check("reset_data", a_data, 72'h0);
        tick();
        tick();

        // Release with go == INIT_GO: nothing sent
        a_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_vld) cnt++;
        end
        check("release_init_go_no_pkt", cnt, 0);

        // Go toggle with ready held high
        a_rdy = 1'b1;
        a_go  = 1'b1;
        wait_a_vld(4);
        check("go_vld", a_vld, 1'b1);
        check("go_data", a_data, exp_pkt(8'd0, 8'h01, 4'h0, 1'b1, 32'h0));
        check("go_parity_odd", ^a_data, 1'b1);
        check("go_payload_bit0", a_data[40], 1'b1);
        tick();
        check("go_vld_one_cycle", a_vld, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_vld) cnt++;
        end
        check("go_single_pkt", cnt, 0);

        // Backpressure: packet held while vkey moves
        a_rdy  = 1'b0;
        a_mode = 4'h3;
        a_key  = 32'h1234_5678;
        a_req  = 1'b1;
        tick();
        a_req = 1'b0;
        wait_a_vld(4);
        check("bp_vld", a_vld, 1'b1);
        check("bp_data", a_data, exp_pkt(8'd1, 8'h02, 4'h3, 1'b1, 32'h1234_5678));
        cap = a_data;
        for (int i = 0; i < 10; i++) begin
            a_key = $urandom;
            tick();
            check("bp_data_stable", a_data, cap);
            check("bp_vld_held", a_vld, 1'b1);
        end
        a_rdy = 1'b1;
        tick();
        check("bp_handshake_first_rdy", a_vld, 1'b0);

        // Table of single events
        for (int v = 0; v < 4; v++) begin
            a_mode = vecs[v].mode;
            a_key  = vecs[v].key;
            if (vecs[v].use_go) a_go = vecs[v].go;
            else a_req = 1'b1;
            tick();
            a_req = 1'b0;
            wait_a_vld(4);
            check($sformatf("vec%0d_vld", v), a_vld, 1'b1);
            check($sformatf("vec%0d_data", v), a_data, vecs[v].exp);
            tick();
        end

        // Heartbeat disabled: silence for 1000 cycles
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (a_vld) cnt++;
        end
        check("hb0_no_pkt", cnt, 0);

        // 300 request pulses under backpressure: first fills SEND, the rest merge
        a_rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a_req = 1'b1;
            tick();
            a_req = 1'b0;
            tick();
        end
        check("merge_held_vld", a_vld, 1'b1);
        check("merge_held_data", a_data, exp_pkt(8'd6, 8'h02, 4'hA, 1'b1, 32'h0000_00FF));
        a_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_vld) begin
                cnt++;
                check("merge_pending_data", a_data, exp_pkt(8'd7, 8'h02, 4'hA, 1'b1, 32'h0000_00FF));
            end
        end
        check("merge_one_pending_pkt", cnt, 1);

        // 256 handshakes: seq runs 8..255 then wraps through 0..7
        for (int i = 0; i < 256; i++) begin
            logic [7:0] es;
            es = 8'(i + 8);
            a_req = 1'b1;
            tick();
            a_req = 1'b0;
            wait_a_vld(4);
            check($sformatf("wrap_seq_%0d", i), {a_vld, a_data[71:64]}, {1'b1, es});
            tick();
        end

        // Reset while a packet waits for ready
        a_rdy = 1'b0;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        wait_a_vld(4);
        check("rst_mid_send_pre_vld", a_vld, 1'b1);
        #2;
        a_rst = 1'b1;
        a_go  = 1'b0;
        #1;
        check("rst_mid_send_vld_async", a_vld, 1'b0);
        check("rst_mid_send_data_async", a_data, 72'h0);
        tick();
        tick();
        a_rst = 1'b0;
        a_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_vld) cnt++;
        end
        check("rst_no_retransmit", cnt, 0);

        // Release with go != INIT_GO: go packet, seq restarted
        a_rst = 1'b1;
        a_go  = 1'b1;
        tick();
        tick();
        a_rst = 1'b0;
        wait_a_vld(5);
        check("rst_go_high_vld", a_vld, 1'b1);
        check("rst_go_high_data", a_data, exp_pkt(8'd0, 8'h01, 4'hA, 1'b1, 32'h0000_00FF));
        tick();

        // dut_b: go toggle, request and heartbeat expiry on the same edge
        b_rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        b_go  = 1'b1;
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
        nb = 0;
        for (int k = 17; k <= 70; k++) begin
            tick();
            if (b_vld && nb < 8) begin
                b_edge[nb] = k;
                b_got[nb]  = b_data;
                nb++;
            end
        end
        check("sim_hb_pkt_count", nb, 6);
        for (int j = 0; j < 6; j++) begin
            if (j < nb) begin
                check($sformatf("sim_hb_edge%0d", j), b_edge[j], bexp[j].edge_n);
                check($sformatf("sim_hb_data%0d", j), b_got[j], bexp[j].exp);
            end else begin
                check($sformatf("sim_hb_missing%0d", j), nb, 6);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
